// File: rtl/fwrisc_trap_ctrl.sv
// fwrisc_trap_ctrl
//   Trap sequencer for the fwrisc execute stage. Accepts synchronous
//   exceptions, N_IRQ level-sensitive interrupt lines and MRET. For a trap it
//   writes MEPC, MTVAL and MCAUSE over the CSR write port on three consecutive
//   cycles, then issues a single PC redirect to the trap vector. MRET gives a
//   one-cycle redirect to MEPC with no CSR writes.
//
//   Optional build macro: FWRISC_TRAP_VECTORED_EN
//     defined   : mtvec[1:0]==2'b01 sends interrupts to base + 4*cause_code
//     undefined : every trap goes to {mtvec[31:2],2'b00}
//
//   Ports
//     clock, reset            clock, synchronous active-high reset
//     i_exc_req/_cause/_pc/_tval   exception request pulse and its payload
//     i_irq, i_irq_en, i_mie  interrupt lines, per-line enables, global enable
//     i_instr_boundary, i_boundary_pc  interrupt may be taken; resume PC
//     i_mret, i_mepc, i_mtvec MRET request pulse, current MEPC / MTVEC
//     o_busy                  sequence in progress (core stalls)
//     o_csr_wen/_waddr/_wdata CSR write port
//     o_pc_load, o_pc_target  one-cycle PC redirect
//     o_mie_clr, o_mie_set    mstatus.MIE save / restore pulses
//     o_irq_pending           registered copy of i_irq
//
//   state      | meaning
//   ST_IDLE    | waiting; arbitrates exc_req > mret > interrupt
//   ST_W_MEPC  | write MEPC, pulse mie_clr
//   ST_W_MTVAL | write MTVAL
//   ST_W_MCAUSE| write MCAUSE
//   ST_REDIRECT| pc_load to trap vector, then back to ST_IDLE

module fwrisc_trap_ctrl #(
  parameter int          N_IRQ           = 4,
  parameter int          IRQ_CAUSE_BASE  = 16,
  parameter logic [5:0]  CSR_MEPC_ADDR   = 6'h29,
  parameter logic [5:0]  CSR_MTVAL_ADDR  = 6'h2B,
  parameter logic [5:0]  CSR_MCAUSE_ADDR = 6'h2A
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_exc_req,
  input  logic [3:0]        i_exc_cause,
  input  logic [31:0]       i_exc_pc,
  input  logic [31:0]       i_exc_tval,
  input  logic [N_IRQ-1:0]  i_irq,
  input  logic [N_IRQ-1:0]  i_irq_en,
  input  logic              i_mie,
  input  logic              i_instr_boundary,
  input  logic [31:0]       i_boundary_pc,
  input  logic              i_mret,
  input  logic [31:0]       i_mepc,
  input  logic [31:0]       i_mtvec,
  output logic              o_busy,
  output logic              o_csr_wen,
  output logic [5:0]        o_csr_waddr,
  output logic [31:0]       o_csr_wdata,
  output logic              o_pc_load,
  output logic [31:0]       o_pc_target,
  output logic              o_mie_clr,
  output logic              o_mie_set,
  output logic [N_IRQ-1:0]  o_irq_pending
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MTVAL,
    ST_W_MCAUSE,
    ST_REDIRECT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_epc, w_epc_nxt;
  logic [31:0]        r_tval, w_tval_nxt;
  logic [31:0]        r_cause, w_cause_nxt;
  logic [N_IRQ-1:0]   r_irq_pending;

  logic               r_busy, r_csr_wen, r_pc_load, r_mie_clr, r_mie_set;
  logic [5:0]         r_csr_waddr;
  logic [31:0]        r_csr_wdata, r_pc_target;

  logic               w_busy_nxt, w_csr_wen_nxt, w_pc_load_nxt;
  logic               w_mie_clr_nxt, w_mie_set_nxt;
  logic [5:0]         w_csr_waddr_nxt;
  logic [31:0]        w_csr_wdata_nxt, w_pc_target_nxt;

  logic [N_IRQ-1:0]   w_irq_act;
  logic [4:0]         w_irq_idx;
  logic [30:0]        w_irq_code;
  logic               w_int_ok;
  logic               w_mret_go;
  logic [31:0]        w_base;
  logic [31:0]        w_redirect_pc;

`ifdef FWRISC_TRAP_VECTORED_EN
  // Byte offset into the vector table; held at zero for exceptions so the
  // redirect only needs the mtvec mode bits.
  logic [31:0]        r_vec_off, w_vec_off_nxt;
`endif

  // Interrupts are judged on the registered lines only.
  assign w_irq_act = r_irq_pending & i_irq_en;
  assign w_int_ok  = i_instr_boundary && i_mie && (|w_irq_act);

  // Lowest set index wins: scan from the top so the lowest hit is written last.
  always_comb begin
    w_irq_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_irq_act[i]) w_irq_idx = 5'(i);
    end
  end

  assign w_irq_code = 31'(IRQ_CAUSE_BASE) + 31'(w_irq_idx);
  assign w_base     = {i_mtvec[31:2], 2'b00};

`ifdef FWRISC_TRAP_VECTORED_EN
  assign w_redirect_pc = (i_mtvec[1:0] == 2'b01) ? (w_base + r_vec_off) : w_base;
`else
  logic w_unused_mtvec_mode;
  assign w_unused_mtvec_mode = ^i_mtvec[1:0];
  assign w_redirect_pc       = w_base;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_epc_nxt   = r_epc;
    w_tval_nxt  = r_tval;
    w_cause_nxt = r_cause;
    w_mret_go   = 1'b0;
`ifdef FWRISC_TRAP_VECTORED_EN
    w_vec_off_nxt = r_vec_off;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_exc_req) begin
          w_epc_nxt   = i_exc_pc;
          w_tval_nxt  = i_exc_tval;
          w_cause_nxt = {28'b0, i_exc_cause};
`ifdef FWRISC_TRAP_VECTORED_EN
          w_vec_off_nxt = '0;
`endif
          w_state_nxt = ST_W_MEPC;
        end else if (i_mret) begin
          w_mret_go = 1'b1;
        end else if (w_int_ok) begin
          w_epc_nxt   = i_boundary_pc;
          w_tval_nxt  = '0;
          w_cause_nxt = {1'b1, w_irq_code};
`ifdef FWRISC_TRAP_VECTORED_EN
          w_vec_off_nxt = {w_irq_code[29:0], 2'b00};
`endif
          w_state_nxt = ST_W_MEPC;
        end
      end
      ST_W_MEPC:   w_state_nxt = ST_W_MTVAL;
      ST_W_MTVAL:  w_state_nxt = ST_W_MCAUSE;
      ST_W_MCAUSE: w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it and
  // line up with the state they describe.
  always_comb begin
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_csr_wen_nxt   = 1'b0;
    w_csr_waddr_nxt = '0;
    w_csr_wdata_nxt = '0;
    w_pc_load_nxt   = 1'b0;
    w_pc_target_nxt = '0;
    w_mie_clr_nxt   = 1'b0;
    w_mie_set_nxt   = 1'b0;
    case (w_state_nxt)
      ST_W_MEPC: begin
        w_csr_wen_nxt   = 1'b1;
        w_csr_waddr_nxt = CSR_MEPC_ADDR;
        w_csr_wdata_nxt = w_epc_nxt;
        w_mie_clr_nxt   = 1'b1;
      end
      ST_W_MTVAL: begin
        w_csr_wen_nxt   = 1'b1;
        w_csr_waddr_nxt = CSR_MTVAL_ADDR;
        w_csr_wdata_nxt = w_tval_nxt;
      end
      ST_W_MCAUSE: begin
        w_csr_wen_nxt   = 1'b1;
        w_csr_waddr_nxt = CSR_MCAUSE_ADDR;
        w_csr_wdata_nxt = w_cause_nxt;
      end
      ST_REDIRECT: begin
        w_pc_load_nxt   = 1'b1;
        w_pc_target_nxt = w_redirect_pc;
      end
      default: begin
        if (w_mret_go) begin
          w_pc_load_nxt   = 1'b1;
          w_pc_target_nxt = i_mepc;
          w_mie_set_nxt   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_epc         <= '0;
      r_tval        <= '0;
      r_cause       <= '0;
      r_irq_pending <= '0;
      r_busy        <= 1'b0;
      r_csr_wen     <= 1'b0;
      r_csr_waddr   <= '0;
      r_csr_wdata   <= '0;
      r_pc_load     <= 1'b0;
      r_pc_target   <= '0;
      r_mie_clr     <= 1'b0;
      r_mie_set     <= 1'b0;
`ifdef FWRISC_TRAP_VECTORED_EN
      r_vec_off     <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_epc         <= w_epc_nxt;
      r_tval        <= w_tval_nxt;
      r_cause       <= w_cause_nxt;
      r_irq_pending <= i_irq;
      r_busy        <= w_busy_nxt;
      r_csr_wen     <= w_csr_wen_nxt;
      r_csr_waddr   <= w_csr_waddr_nxt;
      r_csr_wdata   <= w_csr_wdata_nxt;
      r_pc_load     <= w_pc_load_nxt;
      r_pc_target   <= w_pc_target_nxt;
      r_mie_clr     <= w_mie_clr_nxt;
      r_mie_set     <= w_mie_set_nxt;
`ifdef FWRISC_TRAP_VECTORED_EN
      r_vec_off     <= w_vec_off_nxt;
`endif
    end
  end

  assign o_busy        = r_busy;
  assign o_csr_wen     = r_csr_wen;
  assign o_csr_waddr   = r_csr_waddr;
  assign o_csr_wdata   = r_csr_wdata;
  assign o_pc_load     = r_pc_load;
  assign o_pc_target   = r_pc_target;
  assign o_mie_clr     = r_mie_clr;
  assign o_mie_set     = r_mie_set;
  assign o_irq_pending = r_irq_pending;

endmodule

// File: tb/tb_fwrisc_trap_ctrl.sv
module tb_fwrisc_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        exc_req;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic [3:0]  irq, irq_en;
  logic        mie, instr_boundary;
  logic [31:0] boundary_pc;
  logic        mret;
  logic [31:0] mepc, mtvec;
  logic        busy, csr_wen, pc_load, mie_clr, mie_set;
  logic [5:0]  csr_waddr;
  logic [31:0] csr_wdata, pc_target;
  logic [3:0]  irq_pending;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  fwrisc_trap_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .i_exc_req        (exc_req),
    .i_exc_cause      (exc_cause),
    .i_exc_pc         (exc_pc),
    .i_exc_tval       (exc_tval),
    .i_irq            (irq),
    .i_irq_en         (irq_en),
    .i_mie            (mie),
    .i_instr_boundary (instr_boundary),
    .i_boundary_pc    (boundary_pc),
    .i_mret           (mret),
    .i_mepc           (mepc),
    .i_mtvec          (mtvec),
    .o_busy           (busy),
    .o_csr_wen        (csr_wen),
    .o_csr_waddr      (csr_waddr),
    .o_csr_wdata      (csr_wdata),
    .o_pc_load        (pc_load),
    .o_pc_target      (pc_target),
    .o_mie_clr        (mie_clr),
    .o_mie_set        (mie_set),
    .o_irq_pending    (irq_pending)
  );

  typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET} kind_t;

  typedef struct {
    kind_t       kind;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [3:0]  irq;
    logic [3:0]  irq_en;
    logic [31:0] mtvec;
    logic [31:0] e_mepc;
    logic [31:0] e_mtval;
    logic [31:0] e_mcause;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Called #1 after the edge that accepted the trap; ends in the IDLE cycle
  // that follows REDIRECT.
  task automatic trap_checks(input string nm, input logic [31:0] e_mepc,
                             input logic [31:0] e_mtval, input logic [31:0] e_mcause,
                             input logic [31:0] e_target);
    chk({nm, "_c1_busy"},   32'(busy), 32'd1);
    chk({nm, "_c1_wen"},    32'(csr_wen), 32'd1);
    chk({nm, "_c1_addr"},   32'(csr_waddr), 32'h29);
    chk({nm, "_mepc"},      csr_wdata, e_mepc);
    chk({nm, "_c1_mieclr"}, 32'(mie_clr), 32'd1);
    chk({nm, "_c1_pcload"}, 32'(pc_load), 32'd0);
    tick();
    chk({nm, "_c2_wen"},    32'(csr_wen), 32'd1);
    chk({nm, "_c2_addr"},   32'(csr_waddr), 32'h2B);
    chk({nm, "_mtval"},     csr_wdata, e_mtval);
    chk({nm, "_c2_mieclr"}, 32'(mie_clr), 32'd0);
    tick();
    chk({nm, "_c3_wen"},    32'(csr_wen), 32'd1);
    chk({nm, "_c3_addr"},   32'(csr_waddr), 32'h2A);
    chk({nm, "_mcause"},    csr_wdata, e_mcause);
    tick();
    chk({nm, "_c4_pcload"}, 32'(pc_load), 32'd1);
    chk({nm, "_target"},    pc_target, e_target);
    chk({nm, "_c4_wen"},    32'(csr_wen), 32'd0);
    chk({nm, "_c4_busy"},   32'(busy), 32'd1);
    chk({nm, "_c4_mieset"}, 32'(mie_set), 32'd0);
    tick();
    chk({nm, "_c5_busy"},   32'(busy), 32'd0);
    chk({nm, "_c5_pcload"}, 32'(pc_load), 32'd0);
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_busy"},   32'(busy), 32'd0);
    chk({nm, "_wen"},    32'(csr_wen), 32'd0);
    chk({nm, "_addr"},   32'(csr_waddr), 32'd0);
    chk({nm, "_wdata"},  csr_wdata, 32'd0);
    chk({nm, "_pcload"}, 32'(pc_load), 32'd0);
    chk({nm, "_target"}, pc_target, 32'd0);
    chk({nm, "_mieclr"}, 32'(mie_clr), 32'd0);
    chk({nm, "_mieset"}, 32'(mie_set), 32'd0);
    chk({nm, "_pend"},   32'(irq_pending), 32'd0);
  endtask

  initial begin
    logic seen;
    string nm;

`ifdef FWRISC_TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    //        kind    cause pc            tval          irq      en       mtvec         mepc          mtval         mcause        target
    vecs[0] = '{K_EXC,  4'd11, 32'h8000_0010, 32'h0,        4'b0000, 4'h0,    32'h8000_0100,
                32'h8000_0010, 32'h0,        32'h0000_000B, 32'h8000_0100};
    vecs[1] = '{K_EXC,  4'd2,  32'h8000_0020, 32'hDEAD_BEEF, 4'b0000, 4'h0,   32'h8000_0201,
                32'h8000_0020, 32'hDEAD_BEEF, 32'h0000_0002, 32'h8000_0200};
    vecs[2] = '{K_IRQ,  4'd0,  32'h8000_0040, 32'h0,        4'b0110, 4'hF,    32'h8000_0100,
                32'h8000_0040, 32'h0,        32'h8000_0011, 32'h8000_0100};
    vecs[3] = '{K_IRQ,  4'd0,  32'h8000_0080, 32'h0,        4'b1000, 4'b1000, 32'h8000_0103,
                32'h8000_0080, 32'h0,        32'h8000_0013, 32'h8000_0100};
    vecs[4] = '{K_MRET, 4'd0,  32'h8000_0044, 32'h0,        4'b0000, 4'h0,    32'h8000_0100,
                32'h0,         32'h0,        32'h0,         32'h8000_0044};
    vecs[5] = '{K_IRQ,  4'd0,  32'h8000_00C0, 32'h0,        4'b0100, 4'hF,    32'h8000_0101,
                32'h8000_00C0, 32'h0,        32'h8000_0012,
                VEC ? 32'h8000_0148 : 32'h8000_0100};
    vecs[6] = '{K_IRQ,  4'd0,  32'h8000_0100, 32'h0,        4'b1111, 4'b1100, 32'h8000_0001,
                32'h8000_0100, 32'h0,        32'h8000_0012,
                VEC ? 32'h8000_0048 : 32'h8000_0000};
    vecs[7] = '{K_IRQ,  4'd0,  32'h0000_0004, 32'h0,        4'b0001, 4'b0001, 32'h8000_0001,
                32'h0000_0004, 32'h0,        32'h8000_0010,
                VEC ? 32'h8000_0040 : 32'h8000_0000};

    reset = 1'b1; exc_req = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    irq = '0; irq_en = '0; mie = 1'b0; instr_boundary = 1'b0; boundary_pc = '0;
    mret = 1'b0; mepc = '0; mtvec = '0;
    repeat (3) tick();
    all_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      nm = $sformatf("v%0d", i);
      mtvec = vecs[i].mtvec;
      case (vecs[i].kind)
        K_EXC: begin
          exc_req = 1'b1; exc_cause = vecs[i].cause;
          exc_pc = vecs[i].pc; exc_tval = vecs[i].tval;
          tick();
          exc_req = 1'b0;
          trap_checks(nm, vecs[i].e_mepc, vecs[i].e_mtval, vecs[i].e_mcause, vecs[i].e_target);
        end
        K_IRQ: begin
          irq = vecs[i].irq; irq_en = vecs[i].irq_en; mie = 1'b1;
          instr_boundary = 1'b1; boundary_pc = vecs[i].pc;
          tick();
          chk({nm, "_lat_busy"}, 32'(busy), 32'd0);
          chk({nm, "_pend"}, 32'(irq_pending), 32'(vecs[i].irq));
          tick();
          irq = '0; mie = 1'b0;
          trap_checks(nm, vecs[i].e_mepc, vecs[i].e_mtval, vecs[i].e_mcause, vecs[i].e_target);
        end
        default: begin
          mret = 1'b1; mepc = vecs[i].pc;
          tick();
          mret = 1'b0;
          chk({nm, "_pcload"}, 32'(pc_load), 32'd1);
          chk({nm, "_target"}, pc_target, vecs[i].e_target);
          chk({nm, "_mieset"}, 32'(mie_set), 32'd1);
          chk({nm, "_wen"},    32'(csr_wen), 32'd0);
          chk({nm, "_busy"},   32'(busy), 32'd0);
          tick();
          chk({nm, "_pcload2"}, 32'(pc_load), 32'd0);
          chk({nm, "_mieset2"}, 32'(mie_set), 32'd0);
        end
      endcase
      tick();
    end

    // Masking by mstatus.MIE, then by irq_en, then release.
    irq = 4'b0110; irq_en = 4'hF; mie = 1'b0; instr_boundary = 1'b1;
    boundary_pc = 32'h8000_0040; mtvec = 32'h8000_0100;
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | csr_wen | pc_load | busy; end
    chk("mask_mie_quiet", 32'(seen), 32'd0);
    chk("mask_pending", 32'(irq_pending), 32'b0110);
    mie = 1'b1; irq_en = 4'h0;
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | csr_wen | pc_load | busy; end
    chk("mask_en_quiet", 32'(seen), 32'd0);
    irq_en = 4'hF;
    tick();
    irq = '0; mie = 1'b0;
    trap_checks("unmask", 32'h8000_0040, 32'h0, 32'h8000_0011, 32'h8000_0100);
    tick();

    // Exception and interrupt in the same IDLE cycle: exception first, then
    // the still-pending interrupt in the IDLE cycle after REDIRECT.
    irq = 4'b0100; irq_en = 4'hF; mie = 1'b1; instr_boundary = 1'b1;
    boundary_pc = 32'h8000_0060; mtvec = 32'h8000_0101;
    tick();
    exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 32'h8000_0070; exc_tval = 32'h0000_0123;
    tick();
    exc_req = 1'b0;
    trap_checks("simul_exc", 32'h8000_0070, 32'h0000_0123, 32'h0000_0002, 32'h8000_0100);
    tick();
    irq = '0; mie = 1'b0;
    trap_checks("simul_irq", 32'h8000_0060, 32'h0, 32'h8000_0012,
                VEC ? 32'h8000_0148 : 32'h8000_0100);
    tick();

    // Reset while in W_MTVAL aborts the sequence.
    exc_req = 1'b1; exc_cause = 4'd5; exc_pc = 32'h8000_0090; exc_tval = 32'h44;
    tick();
    exc_req = 1'b0;
    tick();
    chk("rst_mid_in_mtval", 32'(csr_waddr), 32'h2B);
    reset = 1'b1;
    tick();
    all_zero("rst_mid");
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); seen = seen | csr_wen | pc_load | busy; end
    chk("rst_mid_quiet", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
